// File: rtl/flatten.sv
// flatten: parallel-to-serial converter feeding the dense layer.
// On a start pulse in IDLE the packed feature map is latched. The elements
// are then emitted one per clock on flat_out, element 0 first, and done
// pulses together with the last element.
// Optional feature macro: FLATTEN_VALID_EN adds an out_valid strobe that is
// high on every cycle flat_out carries a freshly loaded element.
module flatten #(
    parameter int DATA_W    = 16,
    parameter int NUM_ELEMS = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [DATA_W*NUM_ELEMS-1:0]   feature_map_flat,
    output logic signed [DATA_W-1:0]      flat_out,
`ifdef FLATTEN_VALID_EN
    output logic                          out_valid,
`endif
    output logic                          done
);

    localparam int IDX_W = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                               state;
    logic [IDX_W-1:0]                     index;
    // Element i lives at map_buf[i], matching bits [i*DATA_W +: DATA_W].
    logic [NUM_ELEMS-1:0][DATA_W-1:0]     map_buf;

    // Control FSM, element buffer and registered outputs in one clocked block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            index    <= '0;
            // NOTE: the map buffer is an ordinary register bank, so it is
            // cleared with the rest of the state; a fresh pass never shows
            // data left over from before reset.
            map_buf  <= '0;
            flat_out <= '0;
            done     <= 1'b0;
`ifdef FLATTEN_VALID_EN
            out_valid <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so the default
            // below is simply overridden by a later assignment in this block
            // and every register samples pre-edge values.
            done <= 1'b0;
`ifdef FLATTEN_VALID_EN
            out_valid <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        map_buf <= feature_map_flat;
                        index   <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    flat_out <= map_buf[index];
`ifdef FLATTEN_VALID_EN
                    out_valid <= 1'b1;
`endif
                    if (index == LAST_IDX) begin
                        done  <= 1'b1;
                        index <= '0;
                        state <= IDLE;
                    end else begin
                        index <= index + IDX_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flatten.sv
// Directed testbench for flatten (DATA_W=16, NUM_ELEMS=16).
// Builds with or without FLATTEN_VALID_EN; out_valid is checked when present.
module tb_flatten;

    localparam int DATA_W    = 16;
    localparam int NUM_ELEMS = 16;

    typedef logic [DATA_W-1:0] elem_t;

    logic                        clk;
    logic                        reset;
    logic                        start;
    logic [DATA_W*NUM_ELEMS-1:0] feature_map_flat;
    logic signed [DATA_W-1:0]    flat_out;
    logic                        done;
`ifdef FLATTEN_VALID_EN
    logic                        out_valid;
`endif

    int checks;
    int errors;
    int cyc;
    int last_done_cyc;

    flatten #(
        .DATA_W    (DATA_W),
        .NUM_ELEMS (NUM_ELEMS)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .feature_map_flat (feature_map_flat),
        .flat_out         (flat_out),
`ifdef FLATTEN_VALID_EN
        .out_valid        (out_valid),
`endif
        .done             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs set after this return are sampled at the
    // next edge, and outputs read after it reflect the edge just passed.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [DATA_W*NUM_ELEMS-1:0] pack_map(input elem_t e [NUM_ELEMS]);
        logic [DATA_W*NUM_ELEMS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_ELEMS; i++) m[i*DATA_W +: DATA_W] = e[i];
        return m;
    endfunction

    // Outputs must look idle: flat_out at the given held value, no done.
    task automatic expect_idle(input string name, input elem_t hold_val);
        checks++;
        if (flat_out !== hold_val) begin
            errors++;
            $display("FAIL %s flat_out: got %h expected %h", name, flat_out, hold_val);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s done: got %b expected 0", name, done);
        end
`ifdef FLATTEN_VALID_EN
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s out_valid: got %b expected 0", name, out_valid);
        end
`endif
    endtask

    // Present a map with start for one edge, then scramble the input bus.
    task automatic start_pass(input elem_t e [NUM_ELEMS]);
        feature_map_flat = pack_map(e);
        start = 1'b1;
        step();
        start = 1'b0;
        feature_map_flat = {8{$urandom()}};
    endtask

    // Check NUM_ELEMS output cycles against exp; returns number of done pulses.
    // If busy_at >= 0, start is raised with a junk map after that element.
    task automatic expect_seq(input string name, input elem_t exp [NUM_ELEMS],
                              input int busy_at, output int n_done);
        n_done = 0;
        for (int k = 0; k < NUM_ELEMS; k++) begin
            step();
            if (busy_at >= 0 && k == busy_at + 1) start = 1'b0;
            checks++;
            if (flat_out !== exp[k]) begin
                errors++;
                $display("FAIL %s elem%0d: got %h expected %h", name, k, flat_out, exp[k]);
            end
            checks++;
            if (done !== (k == NUM_ELEMS - 1)) begin
                errors++;
                $display("FAIL %s done@%0d: got %b expected %b", name, k, done, (k == NUM_ELEMS - 1));
            end
`ifdef FLATTEN_VALID_EN
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL %s out_valid@%0d: got %b expected 1", name, k, out_valid);
            end
`endif
            if (done === 1'b1) begin
                n_done++;
                last_done_cyc = cyc;
            end
            if (k == busy_at) begin
                start = 1'b1;
                feature_map_flat = {8{32'hDEAD_BEEF}};
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        feature_map_flat = '0;
        step();
        step();
        expect_idle("reset", 16'h0000);
        reset = 1'b0;
        step();
        expect_idle("post_reset_idle", 16'h0000);
    endtask

    task automatic test_basic();
        elem_t e [NUM_ELEMS];
        int nd;
        for (int i = 0; i < NUM_ELEMS; i++) e[i] = elem_t'(i);
        start_pass(e);
        expect_seq("basic", e, -1, nd);
        step();
        expect_idle("basic_hold1", 16'h000F);
        step();
        expect_idle("basic_hold2", 16'h000F);
    endtask

    task automatic test_signed();
        elem_t e [NUM_ELEMS];
        int nd;
        for (int i = 0; i < NUM_ELEMS; i++) e[i] = 16'h0000;
        e[0] = 16'h8000;
        e[1] = 16'hFFFF;
        e[2] = 16'h7FFF;
        start_pass(e);
        expect_seq("signed", e, -1, nd);
        step();
        expect_idle("signed_hold", 16'h0000);
    endtask

    task automatic test_start_busy();
        elem_t e [NUM_ELEMS];
        int nd;
        int extra;
        for (int i = 0; i < NUM_ELEMS; i++) e[i] = elem_t'(16'h0A00 + 16'(i * 3));
        start_pass(e);
        // Element index 4 is the 5th SHIFT cycle.
        expect_seq("busy", e, 4, nd);
        extra = 0;
        for (int j = 0; j < 3; j++) begin
            step();
            if (done === 1'b1) extra++;
        end
        checks++;
        if (nd + extra !== 1) begin
            errors++;
            $display("FAIL busy_done_count: got %0d expected 1", nd + extra);
        end
        expect_idle("busy_hold", e[NUM_ELEMS-1]);
    endtask

    task automatic test_mid_reset();
        elem_t e [NUM_ELEMS];
        elem_t f [NUM_ELEMS];
        int nd;
        for (int i = 0; i < NUM_ELEMS; i++) e[i] = elem_t'(16'h5500 + 16'(i));
        for (int i = 0; i < NUM_ELEMS; i++) f[i] = elem_t'(16'hC000 - 16'(i));
        start_pass(e);
        for (int k = 0; k < 7; k++) begin
            step();
            checks++;
            if (flat_out !== e[k]) begin
                errors++;
                $display("FAIL midrst_elem%0d: got %h expected %h", k, flat_out, e[k]);
            end
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        expect_idle("midrst_reset", 16'h0000);
        for (int j = 0; j < 12; j++) begin
            step();
            expect_idle("midrst_quiet", 16'h0000);
        end
        // Reset and start together: reset wins, no pass begins.
        reset = 1'b1;
        start = 1'b1;
        feature_map_flat = pack_map(e);
        step();
        reset = 1'b0;
        start = 1'b0;
        expect_idle("rst_and_start", 16'h0000);
        step();
        expect_idle("rst_and_start_after", 16'h0000);
        start_pass(f);
        expect_seq("midrst_fresh", f, -1, nd);
    endtask

    task automatic test_back_to_back();
        elem_t a [NUM_ELEMS];
        elem_t b [NUM_ELEMS];
        int nd;
        int first_done;
        for (int i = 0; i < NUM_ELEMS; i++) a[i] = elem_t'(16'h0200 + 16'(i));
        for (int i = 0; i < NUM_ELEMS; i++) b[i] = elem_t'(16'h0100 + 16'(i));
        start_pass(a);
        expect_seq("b2b_first", a, -1, nd);
        first_done = last_done_cyc;
        start_pass(b);
        // start_pass consumed the first b cycle; element 0 arrives on the next.
        expect_seq("b2b_second", b, -1, nd);
        checks++;
        if (last_done_cyc - first_done !== 17) begin
            errors++;
            $display("FAIL b2b_done_gap: got %0d expected 17", last_done_cyc - first_done);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        last_done_cyc = -100;
        test_reset();
        test_basic();
        test_signed();
        test_start_busy();
        test_mid_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
